// File: rtl/jtag_tap_driver.sv
// Host-side JTAG master: turns reset/IR/DR/idle commands into TMS/TDI sequences on tclk,
// captures TDO, and tracks the target TAP state in a shadow copy.
module jtag_tap_driver #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tclk,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic [3:0]         shadow_state
);

  localparam int unsigned CntW = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [LEN_W-1:0] MaxLenL  = LEN_W'(MAX_LEN);
  localparam logic [CntW-1:0]  MaxLenM1 = CntW'(MAX_LEN - 1);

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpIr    = 2'b01;
  localparam logic [1:0] OpDr    = 2'b10;
  localparam logic [1:0] OpRun   = 2'b11;

  localparam logic [3:0] TapTlr = 4'd0;
  localparam logic [3:0] TapRti = 4'd1;

  typedef enum logic [2:0] {StIdle, StLead, StNav, StShift, StExit, StRun} state_e;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      4'd0:    tap_next = m ? 4'd0  : 4'd1;
      4'd1:    tap_next = m ? 4'd2  : 4'd1;
      4'd2:    tap_next = m ? 4'd9  : 4'd3;
      4'd3:    tap_next = m ? 4'd5  : 4'd4;
      4'd4:    tap_next = m ? 4'd5  : 4'd4;
      4'd5:    tap_next = m ? 4'd8  : 4'd6;
      4'd6:    tap_next = m ? 4'd7  : 4'd6;
      4'd7:    tap_next = m ? 4'd8  : 4'd4;
      4'd8:    tap_next = m ? 4'd2  : 4'd1;
      4'd9:    tap_next = m ? 4'd0  : 4'd10;
      4'd10:   tap_next = m ? 4'd12 : 4'd11;
      4'd11:   tap_next = m ? 4'd12 : 4'd11;
      4'd12:   tap_next = m ? 4'd15 : 4'd13;
      4'd13:   tap_next = m ? 4'd14 : 4'd13;
      4'd14:   tap_next = m ? 4'd15 : 4'd11;
      default: tap_next = m ? 4'd2  : 4'd1;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               tms_q, tms_d, tdi_q, tdi_d;
  logic [3:0]         shadow_q;
  logic [CntW-1:0]    cnt_q, cnt_d, len_q, len_d;
  logic [3:0]         pat_q, pat_d;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d, mask_q, mask_d, rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d, ready_q;

  // Values decoded from the command on the accept edge.
  logic [1:0]      acc_op;
  logic [3:0]      acc_pat;
  logic [CntW-1:0] acc_nav, acc_len_m1, acc_run_m1;

  always_comb begin
    // A shadow outside RTI/TLR while idle means we lost track: recover with a TAP reset.
    acc_op = ((shadow_q != TapRti) && (shadow_q != TapTlr)) ? OpReset : cmd_op;
    if (cmd_len == '0)          acc_len_m1 = '0;
    else if (cmd_len > MaxLenL) acc_len_m1 = MaxLenM1;
    else                        acc_len_m1 = CntW'(cmd_len) - CntOne;
    acc_run_m1 = (cmd_len == '0) ? '0 : CntW'(cmd_len) - CntOne;
    case (acc_op)
      OpIr:    begin acc_pat = 4'b0011; acc_nav = CntW'(4); end
      OpDr:    begin acc_pat = 4'b0001; acc_nav = CntW'(3); end
      default: begin acc_pat = 4'b1111; acc_nav = CntW'(4); end
    endcase
  end

  // state_q names the phase of the bit currently on TMS; each edge picks the next bit.
  always_comb begin
    state_d     = state_q;
    tms_d       = tms_q;
    tdi_d       = 1'b0;
    cnt_d       = cnt_q;
    len_d       = len_q;
    pat_d       = pat_q;
    op_d        = op_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    if (state_q == StShift) begin
      if (tdo) rsp_data_d = rsp_data_q | mask_q;
      mask_d = mask_q << 1;
    end

    unique case (state_q)
      StIdle: begin
        tms_d = 1'b0;
        if (cmd_valid && ready_q) begin
          op_d       = acc_op;
          pat_d      = acc_pat;
          len_d      = acc_len_m1;
          data_d     = cmd_data;
          mask_d     = MAX_LEN'(1);
          rsp_data_d = '0;
          cnt_d      = (acc_op == OpRun) ? acc_run_m1 : acc_nav;
          if (shadow_q == TapTlr) begin
            state_d = StLead;
          end else if (acc_op == OpRun) begin
            state_d = StRun;
          end else begin
            state_d = StNav;
            tms_d   = acc_pat[0];
            pat_d   = acc_pat >> 1;
            cnt_d   = acc_nav - CntOne;
          end
        end
      end
      StLead: begin
        tms_d = 1'b0;
        if (op_q == OpRun) begin
          state_d = StRun;
        end else begin
          state_d = StNav;
          tms_d   = pat_q[0];
          pat_d   = pat_q >> 1;
          cnt_d   = cnt_q - CntOne;
        end
      end
      StNav: begin
        if (cnt_q != '0) begin
          tms_d = pat_q[0];
          pat_d = pat_q >> 1;
          cnt_d = cnt_q - CntOne;
        end else if (op_q == OpReset) begin
          state_d = StExit;
          tms_d   = 1'b1;
          cnt_d   = CntOne;
        end else begin
          state_d = StShift;
          tms_d   = (len_q == '0);
          tdi_d   = data_q[0];
          data_d  = data_q >> 1;
          cnt_d   = len_q;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          state_d = StExit;
          tms_d   = 1'b1;
          cnt_d   = CntOne;
        end else begin
          tms_d  = (cnt_q == CntOne);
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
          cnt_d  = cnt_q - CntOne;
        end
      end
      StExit: begin
        tms_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
        end
      end
      StRun: begin
        tms_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tms_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= StIdle;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      shadow_q    <= TapTlr;
      cnt_q       <= '0;
      len_q       <= '0;
      pat_q       <= '0;
      op_q        <= OpReset;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      shadow_q    <= tap_next(shadow_q, tms_q);
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      op_q        <= op_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= (state_d == StIdle);
    end
  end

  assign cmd_ready    = ready_q;
  assign tms          = tms_q;
  assign tdi          = tdi_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign shadow_state = shadow_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: a target TAP model with a TDO loopback register, a response
// scoreboard, and directed plus random back-to-back commands.
module tb_jtag_tap_driver;

  localparam int unsigned MaxLen = 32;
  localparam int unsigned LenW   = 6;

  logic              tclk = 1'b0;
  logic              trst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [LenW-1:0]   cmd_len = '0;
  logic [MaxLen-1:0] cmd_data = '0;
  logic              cmd_ready, tms, tdi, tdo, rsp_valid;
  logic [MaxLen-1:0] rsp_data;
  logic [3:0]        shadow_state;

  always #5 tclk = ~tclk;

  jtag_tap_driver #(.MAX_LEN(MaxLen), .LEN_W(LenW)) dut (
    .tclk         (tclk),
    .trst_n       (trst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .cmd_data     (cmd_data),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .shadow_state (shadow_state)
  );

  // Target TAP: {next when tms=0, next when tms=1} per state.
  localparam logic [7:0] TapTbl [16] = '{8'h10, 8'h12, 8'h39, 8'h45, 8'h45, 8'h68, 8'h67, 8'h48,
                                         8'h12, 8'hA0, 8'hBC, 8'hBC, 8'hDF, 8'hDE, 8'hBF, 8'h12};

  function automatic logic [3:0] tap_step(input logic [3:0] s, input logic m);
    logic [7:0] e;
    e = TapTbl[s];
    return m ? e[3:0] : e[7:4];
  endfunction

  logic [3:0]  tap_state;
  logic [31:0] lb;
  logic [31:0] lb_seed = 32'h0000_003C;
  assign tdo = lb[0];

  always @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      tap_state <= 4'd0;
      lb        <= lb_seed;
    end else begin
      tap_state <= tap_step(tap_state, tms);
      if (tap_state == 4'd4 || tap_state == 4'd11) lb <= {tdi, lb[31:1]};
    end
  end

  int cyc = 0;
  always @(posedge tclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    int          done;
  } exp_t;
  exp_t sb[$];

  always @(negedge tclk) begin
    exp_t e;
    check_eq("shadow_vs_tap", {28'd0, shadow_state}, {28'd0, tap_state});
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_data", rsp_data, e.data);
        check_eq("rsp_edge", cyc, e.done);
        check_eq("rsp_shadow", {28'd0, shadow_state}, 32'd1);
      end
    end
    if (sb.size() != 0) check_eq("ready_busy", {31'd0, cmd_ready}, 32'd0);
  end

  // Returns #1 after the accept edge; the expected response is queued once accepted.
  task automatic send(input logic [1:0] op, input logic [LenW-1:0] len, input logic [31:0] data);
    int   waited = 0;
    int   l, lat;
    exp_t e;
    @(negedge tclk);
    while (!cmd_ready && waited < 300) begin
      @(negedge tclk);
      waited++;
    end
    if (!cmd_ready) begin
      check_eq("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    l = (len == 0) ? 1 : ((len > MaxLen) ? MaxLen : int'(len));
    case (op)
      2'b00:   lat = 6;
      2'b01:   lat = l + 6;
      2'b10:   lat = l + 5;
      default: lat = (len == 0) ? 1 : int'(len);
    endcase
    if (tap_state == 4'd0) lat = lat + 1;
    e.data = (op == 2'b01 || op == 2'b10) ? (lb & ((l == 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 1)))
                                          : 32'd0;
    e.done = cyc + 1 + lat;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge tclk);
    #1;
    sb.push_back(e);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = LenW'($urandom);
    cmd_data  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge tclk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("rsp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int          dr_sh[13] = '{2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 5, 8, 1};
  int          ir_sh[10] = '{2, 9, 10, 11, 11, 11, 11, 12, 15, 1};
  logic [6:0]  rst_tms = 7'b0111110;
  logic [7:0]  dr_dat = 8'hA5;
  logic [3:0]  ir_dat = 4'h6;

  initial begin
    #1 trst_n = 1'b0;
    #1;
    check_eq("rst_tms", {31'd0, tms}, 32'd1);
    check_eq("rst_tdi", {31'd0, tdi}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_shadow", {28'd0, shadow_state}, 32'd0);
    @(negedge tclk);
    @(negedge tclk);
    #2 trst_n = 1'b1;
    check_eq("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    #4 check_eq("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // TAP reset straight after release: LEAD edge, then 1,1,1,1,1,0.
    send(2'b00, 6'd0, 32'd0);
    for (int e = 0; e <= 6; e++) begin
      @(negedge tclk);
      check_eq("op00_tms", {31'd0, tms}, {31'd0, rst_tms[e]});
    end
    wait_idle();

    // DR shift of 0xA5 against a loopback preloaded with 0x3C.
    send(2'b10, 6'd8, 32'h0000_00A5);
    for (int e = 0; e <= 13; e++) begin
      @(negedge tclk);
      if (e >= 1) check_eq("dr_shadow", {28'd0, shadow_state}, dr_sh[e-1]);
      if (e >= 3 && e <= 10) check_eq("dr_tdi", {31'd0, tdi}, {31'd0, dr_dat[e-3]});
    end
    wait_idle();

    send(2'b01, 6'd4, 32'h0000_0006);
    for (int e = 0; e <= 10; e++) begin
      @(negedge tclk);
      if (e >= 1) check_eq("ir_shadow", {28'd0, shadow_state}, ir_sh[e-1]);
      if (e >= 4 && e <= 7) check_eq("ir_tdi", {31'd0, tdi}, {31'd0, ir_dat[e-4]});
    end
    wait_idle();

    send(2'b11, 6'd3, 32'd0);
    for (int e = 0; e <= 3; e++) begin
      @(negedge tclk);
      check_eq("run_tms", {31'd0, tms}, 32'd0);
      check_eq("run_shadow", {28'd0, shadow_state}, 32'd1);
    end
    wait_idle();
    send(2'b11, 6'd0, 32'd0);
    wait_idle();

    // Reset in the middle of a 16-bit DR shift drops the command.
    send(2'b10, 6'd16, 32'hBEEF);
    repeat (8) @(negedge tclk);
    #2 trst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_tms", {31'd0, tms}, 32'd1);
    check_eq("midrst_shadow", {28'd0, shadow_state}, 32'd0);
    check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("midrst_rsp_data", rsp_data, 32'd0);
    @(negedge tclk);
    #2 trst_n = 1'b1;
    send(2'b10, 6'd12, 32'h0000_0ABC);
    @(negedge tclk);
    check_eq("midrst_lead_tms", {31'd0, tms}, 32'd0);
    wait_idle();

    // Random back-to-back commands, including lengths beyond MAX_LEN.
    for (int i = 0; i < 24; i++) begin
      send(2'($urandom), 6'($urandom_range(0, 40)), $urandom);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
